alu_share_arb: RTL and testbench

Round-robin arbiter and sequencer that shares one combinational 64-bit ALU between `NREQ` requesters (e.g. execute-stage integer ops and address generation). It accepts at most one operation per cycle, drives the shared ALU's operand/control inputs for the granted requester, and captures the ALU result in a single output register. The output register is held under a valid/ready handshake. The block sits between the requesting pipeline stages and the ALU instance; the ALU itself is outside the block.

---
 rtl/alu_share_arb_if.sv | 46 ++++
 rtl/alu_share_arb.sv | 88 ++++++++
 tb/tb_alu_share_arb.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_share_arb_if.sv
// ALU control encoding plus the requester/ALU/response bundle for alu_share_arb.
// The slave modport is the arbiter; the master modport is the surrounding pipeline and ALU.
package common;
   typedef enum logic [3:0] {
      ADD = 4'd0,
      SUB = 4'd1,
      AND = 4'd2,
      OR  = 4'd3,
      XOR = 4'd4,
      SLL = 4'd5,
      SRL = 4'd6,
      SLT = 4'd7
   } ALU_CTR;
endpackage

interface alu_share_arb_if #(
   parameter int NREQ = 2,
   parameter int IDW  = $clog2(NREQ)
);
   logic [NREQ-1:0]                           req_valid;
   logic [NREQ-1:0]                           req_ready;
   logic [NREQ*64-1:0]                        req_a;
   logic [NREQ*64-1:0]                        req_b;
   logic [NREQ*$bits(common::ALU_CTR)-1:0]    req_op;
   logic [63:0]                               alu_a;
   logic [63:0]                               alu_b;
   common::ALU_CTR                            alu_ctrl;
   logic [63:0]                               alu_out;
   logic                                      alu_zero;
   logic                                      resp_valid;
   logic                                      resp_ready;
   logic [63:0]                               resp_data;
   logic                                      resp_zero;
   logic [IDW-1:0]                            resp_id;
   logic [31:0]                               op_count;

   modport slave (
      input  req_valid, req_a, req_b, req_op, alu_out, alu_zero, resp_ready,
      output req_ready, alu_a, alu_b, alu_ctrl, resp_valid, resp_data, resp_zero, resp_id, op_count
   );

   modport master (
      output req_valid, req_a, req_b, req_op, alu_out, alu_zero, resp_ready,
      input  req_ready, alu_a, alu_b, alu_ctrl, resp_valid, resp_data, resp_zero, resp_id, op_count
   );
endinterface

// File: rtl/alu_share_arb.sv
// Round-robin share of one combinational ALU; result registered the cycle a request is granted.
// A held (unconsumed) response blocks all grants; a pop and a new grant may share one cycle.
module alu_share_arb
   import common::*;
#(
   parameter int NREQ = 2,
   parameter int IDW  = $clog2(NREQ)
) (
   input logic            clk,
   input logic            reset,
   alu_share_arb_if.slave bus
);
   localparam int CW = $bits(ALU_CTR);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t          state;
   logic [IDW-1:0]  ptr;
   logic [IDW-1:0]  grant_idx;
   logic [IDW-1:0]  idx;
   logic [IDW:0]    sum;
   logic            grant_vld;
   logic            slot_free;
   logic [63:0]     resp_data_q;
   logic            resp_zero_q;
   logic [IDW-1:0]  resp_id_q;
   logic [31:0]     op_cnt_q;
   logic [63:0]     a_arr  [NREQ];
   logic [63:0]     b_arr  [NREQ];
   ALU_CTR          op_arr [NREQ];

   for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign a_arr[i]  = bus.req_a[64*i +: 64];
      assign b_arr[i]  = bus.req_b[64*i +: 64];
      assign op_arr[i] = ALU_CTR'(bus.req_op[CW*i +: CW]);
   end

   assign slot_free = (state == EMPTY) || bus.resp_ready;

   // Search ptr, ptr+1, ... modulo NREQ; works for non-power-of-two NREQ.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      sum       = '0;
      idx       = '0;
      for (int k = 0; k < NREQ; k++) begin
         sum = {1'b0, ptr} + (IDW+1)'(k);
         if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
         idx = sum[IDW-1:0];
         if (!grant_vld && bus.req_valid[idx]) begin
            grant_vld = 1'b1;
            grant_idx = idx;
         end
      end
      if (reset || !slot_free) grant_vld = 1'b0;
   end

   assign bus.req_ready = grant_vld ? (NREQ'(1) << grant_idx) : '0;
   assign bus.alu_a     = grant_vld ? a_arr[grant_idx]  : '0;
   assign bus.alu_b     = grant_vld ? b_arr[grant_idx]  : '0;
   assign bus.alu_ctrl  = grant_vld ? op_arr[grant_idx] : ADD;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= EMPTY;
         ptr         <= '0;
         resp_data_q <= '0;
         resp_zero_q <= 1'b0;
         resp_id_q   <= '0;
         op_cnt_q    <= '0;
      end else if (grant_vld) begin
         state       <= FULL;
         resp_data_q <= bus.alu_out;
         resp_zero_q <= bus.alu_zero;
         resp_id_q   <= grant_idx;
         ptr         <= (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
         op_cnt_q    <= op_cnt_q + 32'd1;
      end else if (bus.resp_ready) begin
         state <= EMPTY;
      end
   end

   assign bus.resp_valid = (state == FULL);
   assign bus.resp_data  = resp_data_q;
   assign bus.resp_zero  = resp_zero_q;
   assign bus.resp_id    = resp_id_q;
   assign bus.op_count   = op_cnt_q;
endmodule

// File: tb/tb_alu_share_arb.sv
// Scoreboard bench for alu_share_arb: NREQ=2 instance for the main sequence, NREQ=4 instance for fairness.
module tb_alu_share_arb;
   import common::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   alu_share_arb_if #(.NREQ(2)) bus ();
   alu_share_arb_if #(.NREQ(4)) bus4 ();

   alu_share_arb #(.NREQ(2)) dut  (.clk(clk), .reset(reset), .bus(bus));
   alu_share_arb #(.NREQ(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

   function automatic logic [63:0] alu_f(input logic [63:0] a, input logic [63:0] b, input ALU_CTR op);
      case (op)
         ADD:     return a + b;
         SUB:     return a - b;
         AND:     return a & b;
         OR:      return a | b;
         XOR:     return a ^ b;
         SLL:     return a << b[5:0];
         SRL:     return a >> b[5:0];
         SLT:     return {63'd0, $signed(a) < $signed(b)};
         default: return 64'd0;
      endcase
   endfunction

   assign bus.alu_out   = alu_f(bus.alu_a, bus.alu_b, bus.alu_ctrl);
   assign bus.alu_zero  = (bus.alu_out == 64'd0);
   assign bus4.alu_out  = alu_f(bus4.alu_a, bus4.alu_b, bus4.alu_ctrl);
   assign bus4.alu_zero = (bus4.alu_out == 64'd0);

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   typedef struct packed {
      logic [63:0] d;
      logic        z;
      logic [0:0]  id;
   } exp_t;

   exp_t        sbq[$];
   logic [63:0] a  [2];
   logic [63:0] b  [2];
   ALU_CTR      op [2];

   int          m_ptr;
   bit          m_valid;
   logic [31:0] m_cnt;
   logic [63:0] m_data;
   logic        m_zero;
   logic [0:0]  m_id;

   task automatic model_reset();
      m_ptr = 0; m_valid = 0; m_cnt = '0; m_data = '0; m_zero = 1'b0; m_id = '0;
      sbq.delete();
   endtask

   // Called at a falling edge; returns at the next falling edge.
   task automatic step(input logic [1:0] vld, input logic rdy);
      bit   gv;
      int   g;
      exp_t e;
      bus.req_valid  = vld;
      bus.resp_ready = rdy;
      bus.req_a      = {a[1], a[0]};
      bus.req_b      = {b[1], b[0]};
      bus.req_op     = {op[1], op[0]};
      #1;
      gv = 0;
      g  = 0;
      if (!m_valid || rdy) begin
         for (int k = 0; k < 2; k++) begin
            int j;
            j = (m_ptr + k) % 2;
            if (!gv && vld[j]) begin
               gv = 1;
               g  = j;
            end
         end
      end
      chk("req_ready", 64'(bus.req_ready), gv ? 64'(2'b01 << g) : 64'd0);
      if (gv) begin
         e.d  = alu_f(a[g], b[g], op[g]);
         e.z  = (e.d == 64'd0);
         e.id = 1'(g);
         sbq.push_back(e);
      end else begin
         chk("idle_alu_a", bus.alu_a, 64'd0);
         chk("idle_alu_b", bus.alu_b, 64'd0);
         chk("idle_alu_ctrl", 64'(bus.alu_ctrl), 64'(ADD));
      end
      @(posedge clk);
      #1;
      if (gv) begin
         m_valid = 1;
         m_ptr   = (g + 1) % 2;
         m_cnt   = m_cnt + 32'd1;
         if (sbq.size() == 0) begin
            chk("sb_empty", 64'd1, 64'd0);
         end else begin
            e = sbq.pop_front();
            m_data = e.d; m_zero = e.z; m_id = e.id;
         end
      end else if (rdy) begin
         m_valid = 0;
      end
      chk("resp_data", bus.resp_data, m_data);
      chk("resp_zero", 64'(bus.resp_zero), 64'(m_zero));
      chk("resp_id", 64'(bus.resp_id), 64'(m_id));
      chk("resp_valid", 64'(bus.resp_valid), 64'(m_valid));
      chk("op_count", 64'(bus.op_count), 64'(m_cnt));
      @(negedge clk);
   endtask

   initial begin
      int  grants;
      bit  hit;
      reset = 1'b1;
      bus.req_valid = '0; bus.resp_ready = 1'b0;
      bus.req_a = '0; bus.req_b = '0; bus.req_op = '0;
      bus4.req_valid = '0; bus4.resp_ready = 1'b1;
      bus4.req_a = {64'd30, 64'd20, 64'd10, 64'd0};
      bus4.req_b = {64'd3, 64'd2, 64'd1, 64'd0};
      bus4.req_op = '0;
      a[0] = 64'd3; b[0] = 64'd4; op[0] = ADD;
      a[1] = 64'd0; b[1] = 64'd0; op[1] = ADD;
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst_valid", 64'(bus.resp_valid), 64'd0);
      chk("rst_count", 64'(bus.op_count), 64'd0);
      chk("rst_ready", 64'(bus.req_ready), 64'd0);
      reset = 1'b0;

      // Pending response, then asynchronous reset mid-cycle.
      step(2'b01, 1'b0);
      step(2'b01, 1'b0);
      bus.req_valid = 2'b01;
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("async_rst_valid", 64'(bus.resp_valid), 64'd0);
      chk("async_rst_count", 64'(bus.op_count), 64'd0);
      chk("async_rst_ready", 64'(bus.req_ready), 64'd0);
      model_reset();
      @(negedge clk);
      reset = 1'b0;

      a[0] = 64'd5; b[0] = 64'd7; op[0] = ADD;
      step(2'b01, 1'b1);
      chk("add_5_7", bus.resp_data, 64'd12);
      chk("add_zero", 64'(bus.resp_zero), 64'd0);
      chk("add_id", 64'(bus.resp_id), 64'd0);

      // Round-robin alternation.
      a[0] = 64'd9;    b[0] = 64'd9;    op[0] = SUB;
      a[1] = 64'hF0;   b[1] = 64'h0F;   op[1] = XOR;
      repeat (6) step(2'b11, 1'b1);

      // Back-pressure on a full slot, then pop+push with no bubble.
      a[1] = 64'h100; b[1] = 64'h23; op[1] = ADD;
      repeat (3) step(2'b10, 1'b0);
      step(2'b10, 1'b1);
      chk("bp_no_bubble_valid", 64'(bus.resp_valid), 64'd1);
      chk("bp_no_bubble_data", bus.resp_data, 64'h123);

      // Drain with no requests, then pointer still selects req0.
      step(2'b00, 1'b1);
      step(2'b00, 1'b1);
      a[0] = 64'hFFFF_0000; b[0] = 64'h00FF_FF00; op[0] = AND;
      step(2'b11, 1'b1);
      chk("post_drain_id", 64'(bus.resp_id), 64'd0);

      a[0] = 64'd2; b[0] = 64'd5; op[0] = SLT;
      a[1] = 64'd1; b[1] = 64'd4; op[1] = SLL;
      repeat (2) step(2'b11, 1'b1);

      // op_count wrap.
      force dut.op_cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.op_cnt_q;
      m_cnt = 32'hFFFF_FFFF;
      step(2'b01, 1'b1);
      chk("wrap_count", 64'(bus.op_count), 64'd0);
      step(2'b00, 1'b1);

      // Fairness on NREQ=4: req0 steady, req3 raised once.
      bus4.req_valid = 4'b0001;
      repeat (2) @(negedge clk);
      bus4.req_valid = 4'b1001;
      grants = 0;
      hit    = 0;
      for (int c = 0; c < 8 && !hit; c++) begin
         #1;
         if (bus4.req_ready[3]) hit = 1;
         else if (bus4.req_ready != 4'b0000) grants++;
         @(posedge clk);
         #1;
         if (hit) begin
            chk("fair_id", 64'(bus4.resp_id), 64'd3);
            chk("fair_ptr", 64'(dut4.ptr), 64'd0);
         end
         @(negedge clk);
      end
      chk("fair_hit", 64'(hit), 64'd1);
      chk("fair_wait", 64'(grants), 64'd0);
      bus4.req_valid = 4'b0001;
      #1;
      chk("fair_next_req0", 64'(bus4.req_ready), 64'b0001);
      @(negedge clk);
      bus4.req_valid = 4'b0000;
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
